// File: rtl/truth_tt_pkg.sv
// Shared definitions for the truth-table sweep controller: state encoding
// and the vector-count helper used to size the truth-table buses.
package truth_tt_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_SAMPLE = ST_SAMPLE,
        S_DONE   = ST_DONE
    } state_t;

    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with a zero flag; times how long each input vector
// is held before the function output is sampled.
module settle_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Clocked exhaustive sweep of a small combinational function against an expected
// truth table. Optional macro TT_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for start; results of the last sweep are held
//   S_SETTLE | current vector driven, settle counter running
//   S_SAMPLE | dut_s captured and compared at the closing edge
//   S_DONE   | one-cycle done pulse, pass valid
module truth_table_sequencer
    import truth_tt_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [vec_count(N_IN)-1:0]   exp_tt,
    input  logic                         dut_s,
    output logic [N_IN-1:0]              vec,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [N_IN:0]                fail_count,
    output logic [N_IN-1:0]              fail_idx,
    output logic [vec_count(N_IN)-1:0]   got_tt
);

    localparam int VEC_CNT = vec_count(N_IN);
    localparam int CW      = $clog2(SETTLE) + 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

    state_t               state;
    logic [VEC_CNT-1:0]   exp_q;
    logic                 mism;
    logic                 last_vec;
    logic                 stop_now;
    logic [N_IN:0]        fc_next;
    logic                 cnt_load;
    logic                 cnt_en;
    logic                 cnt_zero;

    assign mism     = (dut_s != exp_q[vec]);
    assign last_vec = (vec == '1);
    assign fc_next  = fail_count + (N_IN+1)'(mism);

`ifdef TT_STOP_ON_FAIL_EN
    assign stop_now = mism;
`else
    assign stop_now = 1'b0;
`endif

    // Reload for every vector so each one gets exactly SETTLE cycles.
    assign cnt_load = ((state == S_IDLE) && start) ||
                      ((state == S_SAMPLE) && !last_vec && !stop_now);
    assign cnt_en   = (state == S_SETTLE);

    settle_counter #(.W(CW)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (SETTLE_LOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            exp_q      <= '0;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
            fail_idx   <= '0;
            got_tt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        exp_q      <= exp_tt;
                        fail_count <= '0;
                        fail_idx   <= '0;
                        got_tt     <= '0;
                        pass       <= 1'b0;
                        vec        <= '0;
                        busy       <= 1'b1;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_zero) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    got_tt[vec] <= dut_s;
                    fail_count  <= fc_next;
                    if (mism && (fail_count == '0)) begin
                        fail_idx <= vec;
                    end
                    // pass is settled on entry to DONE so it is valid alongside done.
                    if (last_vec || stop_now) begin
                        done  <= 1'b1;
                        pass  <= (fc_next == '0);
                        state <= S_DONE;
                    end else begin
                        vec   <= vec + N_IN'(1);
                        state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: two sequencer instances (SETTLE=1 and SETTLE=3) sweeping s = ~x & y.
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start3;
    logic [3:0] exp_tt;

    logic [1:0] vec1, vec3;
    logic       busy1, busy3, done1, done3, pass1, pass3;
    logic [2:0] fc1, fc3;
    logic [1:0] fidx1, fidx3;
    logic [3:0] got1, got3;
    logic       dut_s1, dut_s3;

    assign dut_s1 = ~vec1[1] & vec1[0];
    assign dut_s3 = ~vec3[1] & vec3[0];

    truth_table_sequencer #(.N_IN(2), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_tt(exp_tt), .dut_s(dut_s1),
        .vec(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fc1), .fail_idx(fidx1), .got_tt(got1)
    );

    truth_table_sequencer #(.N_IN(2), .SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .exp_tt(exp_tt), .dut_s(dut_s3),
        .vec(vec3), .busy(busy3), .done(done3), .pass(pass3),
        .fail_count(fc3), .fail_idx(fidx3), .got_tt(got3)
    );

    bit         sel;
    logic [1:0] o_vec, o_fidx;
    logic       o_busy, o_done, o_pass;
    logic [2:0] o_fc;
    logic [3:0] o_got;

    always_comb begin
        o_vec = vec1; o_busy = busy1; o_done = done1; o_pass = pass1;
        o_fc = fc1; o_fidx = fidx1; o_got = got1;
        if (sel) begin
            o_vec = vec3; o_busy = busy3; o_done = done3; o_pass = pass3;
            o_fc = fc3; o_fidx = fidx3; o_got = got3;
        end
    end

    typedef struct {
        logic       pass;
        logic [2:0] fc;
        logic [1:0] fidx;
        logic [3:0] got;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference: evaluate the gate for every vector, independent of the FSM.
    function automatic exp_t model(input logic [3:0] e, input int settle);
        exp_t       r;
        logic [1:0] vv;
        logic       s;
        r.got = '0; r.fc = '0; r.fidx = '0;
        r.done_cyc = 4 * (settle + 1) + 1;
        for (int v = 0; v < 4; v++) begin
            vv = v[1:0];
            s  = ~vv[1] & vv[0];
            r.got[v] = s;
            if (s != e[v]) begin
                if (r.fc == 0) r.fidx = vv;
                r.fc = r.fc + 3'd1;
`ifdef TT_STOP_ON_FAIL_EN
                r.done_cyc = (v + 1) * (settle + 1) + 1;
                break;
`endif
            end
        end
        r.pass = (r.fc == 0);
        return r;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start3 = v; else start1 = v;
    endtask

    task automatic sweep(input bit s3_sel, input logic [3:0] e, input string name,
                         input bit poke, input bit hold);
        exp_t cur, got_e;
        int   settle, ncyc, done_cnt, ev;
        bit   vec_ok;
        sel    = s3_sel;
        settle = s3_sel ? 3 : 1;
        exp_tt = e;
        cur    = model(e, settle);
        sb.push_back(cur);
        if (hold) begin
            got_e = cur;
            got_e.done_cyc = cur.done_cyc + 10;
            sb.push_back(got_e);
        end
        ncyc     = hold ? cur.done_cyc + 14 : cur.done_cyc + 3;
        done_cnt = 0;
        vec_ok   = 1'b1;
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_start(1'b0);
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge clk);
            if (poke) set_start((cyc >= 2 && cyc <= 6) ? 1'b1 : 1'b0);
            if (hold && cyc == 12) set_start(1'b0);
            if (cyc == 1) begin
                total++;
                if (o_pass !== 1'b0 || o_fc !== 3'd0 || o_got !== 4'd0) begin
                    bad++;
                    $display("FAIL %s_start_clear: pass=%b fc=%0d got=%b want 0/0/0000",
                             name, o_pass, o_fc, o_got);
                end
            end
            if (cyc < cur.done_cyc) begin
                ev = (cyc - 1) / (settle + 1);
                if (o_vec !== ev[1:0]) vec_ok = 1'b0;
            end
            if (!hold || cyc <= cur.done_cyc) begin
                if (o_busy !== ((cyc <= cur.done_cyc) ? 1'b1 : 1'b0)) begin
                    total++; bad++;
                    $display("FAIL %s_busy: cycle %0d busy=%b", name, cyc, o_busy);
                end
            end
            if (hold && (cyc == 10 || cyc == 11)) begin
                total++;
                if (o_busy !== ((cyc == 11) ? 1'b1 : 1'b0)) begin
                    bad++;
                    $display("FAIL %s_restart_busy: cycle %0d busy=%b", name, cyc, o_busy);
                end
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL %s_extra_done: done at cycle %0d with nothing expected", name, cyc);
                end else begin
                    got_e = sb.pop_front();
                    if (cyc !== got_e.done_cyc || o_pass !== got_e.pass || o_fc !== got_e.fc ||
                        o_fidx !== got_e.fidx || o_got !== got_e.got) begin
                        bad++;
                        $display("FAIL %s_result: cyc=%0d pass=%b fc=%0d idx=%0d got=%b want cyc=%0d pass=%b fc=%0d idx=%0d got=%b",
                                 name, cyc, o_pass, o_fc, o_fidx, o_got,
                                 got_e.done_cyc, got_e.pass, got_e.fc, got_e.fidx, got_e.got);
                    end
                end
            end
        end
        set_start(1'b0);
        total++;
        if (sb.size() != 0 || done_cnt != (hold ? 2 : 1)) begin
            bad++;
            $display("FAIL %s_done_count: done pulses=%0d pending=%0d want %0d/0",
                     name, done_cnt, sb.size(), hold ? 2 : 1);
        end
        sb.delete();
        total++;
        if (!vec_ok) begin
            bad++;
            $display("FAIL %s_vec_seq: vec sequence off, last vec=%0d", name, o_vec);
        end
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_after: busy=%b done=%b want 0/0", name, o_busy, o_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({vec1, busy1, done1, pass1, fc1, fidx1, got1} !== 14'd0) begin
            bad++;
            $display("FAIL reset_s1: outputs=%h want 0", {vec1, busy1, done1, pass1, fc1, fidx1, got1});
        end
        total++;
        if ({vec3, busy3, done3, pass3, fc3, fidx3, got3} !== 14'd0) begin
            bad++;
            $display("FAIL reset_s3: outputs=%h want 0", {vec3, busy3, done3, pass3, fc3, fidx3, got3});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pass();
        sweep(1'b0, 4'b0010, "pass", 1'b0, 1'b0);
    endtask

    task automatic test_mismatch();
        sweep(1'b0, 4'b1010, "mismatch", 1'b0, 1'b0);
    endtask

    task automatic test_settle3();
        sweep(1'b1, 4'b0010, "settle3", 1'b0, 1'b0);
    endtask

    task automatic test_midsweep_reset();
        sel    = 1'b0;
        exp_tt = 4'b0010;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) @(negedge clk);
        total++;
        if (busy1 !== 1'b1 || vec1 !== 2'd1) begin
            bad++;
            $display("FAIL midreset_before: busy=%b vec=%0d want 1/1", busy1, vec1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({vec1, busy1, done1, pass1, fc1, fidx1, got1} !== 14'd0) begin
            bad++;
            $display("FAIL midreset_clear: outputs=%h want 0", {vec1, busy1, done1, pass1, fc1, fidx1, got1});
        end
        sweep(1'b0, 4'b0010, "after_reset", 1'b0, 1'b0);
    endtask

    task automatic test_busy_start();
        sweep(1'b0, 4'b0010, "busy_start", 1'b1, 1'b0);
    endtask

    task automatic test_first_fail();
        sweep(1'b0, 4'b0011, "first_fail", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        sweep(1'b0, 4'b0110, "back_to_back", 1'b0, 1'b1);
    endtask

    initial begin
        start1 = 1'b0;
        start3 = 1'b0;
        exp_tt = 4'b0000;
        sel    = 1'b0;
        rst_n  = 1'b0;
        test_reset();
        test_pass();
        test_mismatch();
        test_settle3();
        test_midsweep_reset();
        test_busy_start();
        test_first_fail();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Controller that exhaustively sweeps the inputs of a small combinational logic function (e.g. the 2-input `s = f(x, y)` gate network) through every input combination. It waits a programmable settle time at each vector, samples the function output, and compares it against an expected truth table. It reports the pass/fail result, the mismatch count and the captured truth table. It sits between a start/result interface and the combinational block under test, replacing hand-written `#1` stimulus sequences with a clocked, self-checking sweep.

## Interface
- `N_IN`, 2: number of function inputs; sweep covers 2^N_IN vectors (1..6).
- `SETTLE`, 1: cycles each vector is held before sampling (≥1).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `start` input 1: request a sweep; sampled only in IDLE.
- `exp_tt` input 2^N_IN: expected output; bit i = expected `s` for vector i; sampled with `start`.
- `dut_s` input 1: output of the function under test.
- `vec` output N_IN: drives function inputs; MSB = first input (`x`), LSB = last (`y`).
- `busy` output 1: high from the cycle after `start` is accepted until the end of the DONE state.
- `done` output 1: one-cycle pulse at end of sweep.
- `pass` output 1: registered, 1 when `fail_count == 0`; valid from `done`, held until next accepted `start`.
- `fail_count` output N_IN+1: number of mismatching vectors.
- `fail_idx` output N_IN: index of first mismatch; 0 if none.
- `got_tt` output 2^N_IN: captured `dut_s` per vector.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: `start`=1 latches `exp_tt`, clears `fail_count`, `fail_idx`, `got_tt` and `pass`, sets `vec`=0 → SETTLE.
- SETTLE: held exactly SETTLE cycles by a down-counter loaded with SETTLE-1; counter at 0 → SAMPLE.
- SAMPLE (1 cycle): at its closing edge, `got_tt[vec] <= dut_s`. On mismatch with `exp_tt[vec]`, `fail_count` increments, and `fail_idx <= vec` if this is the first mismatch. If `vec == 2^N_IN-1` → DONE, else `vec <= vec+1` → SETTLE.
- DONE (1 cycle): `done`=1, `pass` updates → IDLE.
- `vec` holds its last value in IDLE/DONE. `vec` increments without wrap; the terminal vector ends the sweep.
- `start` during busy is ignored and not queued. `start` held high in IDLE after DONE restarts a sweep.
- `rst_n`=0 at any edge, including mid-sweep, forces IDLE. All outputs and registers go to 0; the sweep is abandoned.

## Timing
- Reset values: `vec`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `fail_idx`=0, `got_tt`=0.
- With `start` sampled at edge 0, each vector occupies SETTLE+1 cycles. `done` is high in cycle 2^N_IN·(SETTLE+1)+1.
- Example, N_IN=2, SETTLE=1: vectors occupy cycles 1–8; `done` is high in cycle 9.
- `dut_s` must be stable by the end of the SAMPLE cycle. The function is purely combinational, so SETTLE=1 is sufficient.

## Configuration
- `TT_STOP_ON_FAIL_EN` defined: the first mismatch in SAMPLE goes directly to DONE. `fail_count`=1, `fail_idx` = failing vector, and `got_tt` bits above that vector remain 0.
- `TT_STOP_ON_FAIL_EN` undefined: the full sweep always runs and `fail_count` counts all mismatches.

## Structure
- Shared package `truth_tt_pkg`: state encoding localparams (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3) and the helper constant for vector count, 2^N_IN.
- One sub-module, `settle_counter`: loadable down-counter with a zero flag, width $clog2(SETTLE)+1.
- Remaining FSM, comparator and capture registers stay in the top module.

## Test plan
- N_IN=2, SETTLE=1, DUT `s = ~x & y`, `exp_tt`=4'b0010, `start` pulse → `done` in cycle 9, `pass`=1, `fail_count`=0, `got_tt`=4'b0010, `vec` sequence 0,0,1,1,2,2,3,3.
- Same DUT, `exp_tt`=4'b1010 → `pass`=0, `fail_count`=1, `fail_idx`=3, `got_tt`=4'b0010.
- SETTLE=3, `exp_tt`=4'b0010 → each vector held 4 cycles; `done` in cycle 17; `pass`=1.
- `rst_n`=0 for one edge at cycle 4 → all outputs 0 next cycle. A new `start` afterwards completes normally with `pass`=1.
- `start` re-asserted in cycles 2–6 while busy → ignored; exactly one `done` pulse at cycle 9.
- `TT_STOP_ON_FAIL_EN` defined, `exp_tt`=4'b0011 → mismatch at vector 0; `done` in cycle 3, `fail_count`=1, `fail_idx`=0.
